// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Groups every non-clock/reset signal of alu_sequencer into one bundle.
//   slave  : sequencer view (receives instructions, drives ALU/register file)
//   master : environment view (fetch/decode, ALU and register file side)
// Signals:
//   instr[7:0], instr_valid, instr_ready      instruction handshake
//   busy, done, illegal                        status
//   rf_addr[3:0], rf_rdata[3:0], rf_we,
//   rf_wdata[3:0]                              index register file port
//   alu_op[3:0], alu_acc[3:0], alu_tmp[3:0],
//   alu_opa[3:0], alu_cin                      ALU operand drive
//   alu_result[3:0], alu_cout, alu_zero        ALU results
//   acc[3:0], cy                               architectural ACC / CY
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [3:0] rf_addr;
  logic [3:0] rf_rdata;
  logic       rf_we;
  logic [3:0] rf_wdata;
  logic [3:0] alu_op;
  logic [3:0] alu_acc;
  logic [3:0] alu_tmp;
  logic [3:0] alu_opa;
  logic       alu_cin;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       alu_zero;
  logic [3:0] acc;
  logic       cy;

  modport slave (
    input  instr, instr_valid, rf_rdata, alu_result, alu_cout, alu_zero,
    output instr_ready, busy, done, illegal, rf_addr, rf_we, rf_wdata,
           alu_op, alu_acc, alu_tmp, alu_opa, alu_cin, acc, cy
  );

  modport master (
    output instr, instr_valid, rf_rdata, alu_result, alu_cout, alu_zero,
    input  instr_ready, busy, done, illegal, rf_addr, rf_we, rf_wdata,
           alu_op, alu_acc, alu_tmp, alu_opa, alu_cin, acc, cy
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle execute sequencer for the 4-bit ALU. Accepts one 8-bit
// instruction ([7:4] opcode, [3:0] OPA) per handshake, optionally reads the
// index register file (RD), drives the external ALU for one cycle (EX),
// optionally writes a register back (WB), and owns the ACC and CY registers.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_sequencer_if.slave (handshake, status, register file, ALU,
//          ACC/CY outputs)
// Parameters:
//   ACC_RST_VAL : ACC value on reset
//   CY_RST_VAL  : CY value on reset
// Configuration macro:
//   ALU_SEQ_EXT_OPS_EN : enables F-group subcodes RAL(5), RAR(6), TCC(7),
//                        DAC(8); without it those subcodes are illegal.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter logic [3:0] ACC_RST_VAL = 4'h0,
  parameter logic       CY_RST_VAL  = 1'b0
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_XCH = 4'hB;
  localparam logic [3:0] OP_LDM = 4'hD;
  localparam logic [3:0] OP_GRP = 4'hF;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h8;
  localparam logic [3:0] ALU_SUB = 4'h9;
  localparam logic [3:0] ALU_LD  = 4'hD;

  state_t     state_q, state_next;
  logic [7:0] ir_q, ir_next;
  logic [3:0] tmp_q, tmp_next;
  logic [3:0] wb_q, wb_next;
  logic [3:0] acc_q, acc_next;
  logic       cy_q, cy_next;

  logic [3:0] opcode;
  logic [3:0] opa;

  // alu_zero is part of the ALU port set but carries no meaning here.
  logic unused_alu_zero;
  assign unused_alu_zero = bus.alu_zero;

  assign opcode = ir_q[7:4];
  assign opa    = ir_q[3:0];

  function automatic logic needs_rd(input logic [3:0] op);
    return (op == OP_INC) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_LD)  || (op == OP_XCH);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      tmp_q   <= '0;
      wb_q    <= '0;
      acc_q   <= ACC_RST_VAL;
      cy_q    <= CY_RST_VAL;
    end else begin
      state_q <= state_next;
      ir_q    <= ir_next;
      tmp_q   <= tmp_next;
      wb_q    <= wb_next;
      acc_q   <= acc_next;
      cy_q    <= cy_next;
    end
  end

  always_comb begin
    state_next      = state_q;
    ir_next         = ir_q;
    tmp_next        = tmp_q;
    wb_next         = wb_q;
    acc_next        = acc_q;
    cy_next         = cy_q;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    bus.rf_addr     = '0;
    bus.rf_we       = 1'b0;
    bus.rf_wdata    = '0;
    bus.alu_op      = ALU_NOP;
    bus.alu_acc     = '0;
    bus.alu_opa     = '0;
    bus.alu_cin     = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          ir_next    = bus.instr;
          state_next = needs_rd(bus.instr[7:4]) ? S_RD : S_EX;
        end
      end

      S_RD: begin
        bus.rf_addr = opa;
        tmp_next    = bus.rf_rdata;
        state_next  = S_EX;
      end

      S_EX: begin
        // INC and XCH finish in WB; everything else (incl. illegal) ends here.
        if (opcode == OP_INC || opcode == OP_XCH) begin
          state_next = S_WB;
        end else begin
          state_next = S_IDLE;
          bus.done   = 1'b1;
        end

        case (opcode)
          OP_NOP: ;
          OP_LDM: begin
            bus.alu_op  = ALU_LD;
            bus.alu_acc = acc_q;
            bus.alu_opa = opa;
            bus.alu_cin = cy_q;
            acc_next    = bus.alu_result;
            cy_next     = bus.alu_cout;
          end
          OP_ADD, OP_SUB: begin
            bus.alu_op  = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
            bus.alu_acc = acc_q;
            bus.alu_opa = tmp_q;
            bus.alu_cin = cy_q;
            acc_next    = bus.alu_result;
            cy_next     = bus.alu_cout;
          end
          OP_LD, OP_XCH: begin
            bus.alu_op  = ALU_LD;
            bus.alu_acc = acc_q;
            bus.alu_opa = tmp_q;
            bus.alu_cin = cy_q;
            acc_next    = bus.alu_result;
            cy_next     = bus.alu_cout;
            if (opcode == OP_XCH) wb_next = acc_q;
          end
          OP_INC: begin
            bus.alu_op  = ALU_ADD;
            bus.alu_acc = tmp_q;
            bus.alu_opa = 4'h1;
            bus.alu_cin = 1'b0;
            wb_next     = bus.alu_result;
          end
          OP_GRP: begin
            case (opa)
              4'h0: begin
                acc_next = '0;
                cy_next  = 1'b0;
              end
              4'h1: cy_next = 1'b0;
              4'h2: begin
                bus.alu_op  = ALU_ADD;
                bus.alu_acc = acc_q;
                bus.alu_opa = 4'h1;
                bus.alu_cin = 1'b0;
                acc_next    = bus.alu_result;
                cy_next     = bus.alu_cout;
              end
              4'h3: cy_next = ~cy_q;
              4'hA: cy_next = 1'b1;
`ifdef ALU_SEQ_EXT_OPS_EN
              4'h5: {cy_next, acc_next} = {acc_q, cy_q};
              4'h6: {acc_next, cy_next} = {cy_q, acc_q};
              4'h7: begin
                acc_next = {3'b000, cy_q};
                cy_next  = 1'b0;
              end
              4'h8: begin
                bus.alu_op  = ALU_ADD;
                bus.alu_acc = acc_q;
                bus.alu_opa = 4'hF;
                bus.alu_cin = 1'b0;
                acc_next    = bus.alu_result;
                cy_next     = bus.alu_cout;
              end
`endif
              default: bus.illegal = 1'b1;
            endcase
          end
          default: bus.illegal = 1'b1;
        endcase
      end

      S_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_addr  = opa;
        bus.rf_wdata = wb_q;
        bus.done     = 1'b1;
        state_next   = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.alu_tmp = '0;
  assign bus.acc     = acc_q;
  assign bus.cy      = cy_q;

endmodule
